cpu: RTL and testbench

//  Single-cycle 4-bit accumulator CPU (TD4-class) with two data registers A and B.
//  - Instruction memory is external: the CPU outputs pc and receives the 8-bit instruction at that address.
//  - Top of the FourBitCPU design; no data I/O ports.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/cpu_register_file.sv | 29 ++
 rtl/cpu.sv | 108 ++++++++++
 tb/tb_cpu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit accumulator CPU: opcode encodings and bench timing.
package cpu_pkg;

    localparam logic [3:0] OP_ADD_A    = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B    = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC      = 4'b1110;
    localparam logic [3:0] OP_JMP      = 4'b1111;

    localparam int HCYCL = 5;
    localparam int STROB = 1;

endpackage

// File: rtl/cpu_register_file.sv
// 4-bit data register with load enable and asynchronous active-low clear.
module register_file (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] dat_in,
    output logic [3:0] dat_out
);

    logic [3:0] dat_q, dat_d;

    always_comb begin
        dat_d = dat_q;
        if (load) begin
            dat_d = dat_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q <= 4'h0;
        end else begin
            dat_q <= dat_d;
        end
    end

    assign dat_out = dat_q;

endmodule

// File: rtl/cpu.sv
// Single-cycle TD4-class CPU: decodes the instruction at pc and updates A, B, C and pc each edge.
module cpu
    import cpu_pkg::*;
(
    input  logic       clk_cpu,
    input  logic       reset,
    input  logic [7:0] inst,
    output logic [3:0] pc
);

    logic [3:0] opcode, imm;
    logic [3:0] a_q, b_q, a_d, b_d;
    logic       load_a, load_b;
    logic [3:0] pc_q, pc_d;
    logic       c_q, c_d;
    logic [3:0] add_src;
    logic [4:0] sum;

    assign opcode = inst[7:4];
    assign imm    = inst[3:0];

    // One shared adder; only ADD B takes B as its operand.
    assign add_src = (opcode == OP_ADD_B) ? b_q : a_q;
    assign sum     = {1'b0, add_src} + {1'b0, imm};

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        load_a = 1'b0;
        load_b = 1'b0;
        c_d    = 1'b0;
        pc_d   = pc_q + 4'd1;
        case (opcode)
            OP_ADD_A: begin
                a_d    = sum[3:0];
                c_d    = sum[4];
                load_a = 1'b1;
            end
            OP_ADD_B: begin
                b_d    = sum[3:0];
                c_d    = sum[4];
                load_b = 1'b1;
            end
            OP_MOV_A_IM: begin
                a_d    = imm;
                load_a = 1'b1;
            end
            OP_MOV_B_IM: begin
                b_d    = imm;
                load_b = 1'b1;
            end
            OP_MOV_A_B: begin
                a_d    = b_q;
                load_a = 1'b1;
            end
            OP_MOV_B_A: begin
                b_d    = a_q;
                load_b = 1'b1;
            end
            OP_IN_A: begin
                a_d    = 4'h0;
                load_a = 1'b1;
            end
            OP_IN_B: begin
                b_d    = 4'h0;
                load_b = 1'b1;
            end
            OP_JMP: pc_d = imm;
            // Tests the carry left by the previous instruction; C itself is cleared here.
            OP_JNC: begin
                if (!c_q) begin
                    pc_d = imm;
                end
            end
            OP_OUT_B, OP_OUT_IM: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            pc_q <= 4'h0;
            c_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            c_q  <= c_d;
        end
    end

    register_file register_file_a (
        .clk     (clk_cpu),
        .rst_n   (reset),
        .load    (load_a),
        .dat_in  (a_d),
        .dat_out (a_q)
    );

    register_file register_file_b (
        .clk     (clk_cpu),
        .rst_n   (reset),
        .load    (load_b),
        .dat_in  (b_d),
        .dat_out (b_q)
    );

    assign pc = pc_q;

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: directed vectors and random programs against a behavioural model.
module tb_cpu;
    import cpu_pkg::*;

    typedef struct {
        logic [7:0] inst;
        int         pc;
        int         a;
        int         b;
        int         c;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] inst;
    logic [3:0] pc;

    exp_t exp_q[$];
    exp_t vecs[16];
    int   n_total;
    int   n_pass;
    int   n_step;

    int m_pc, m_a, m_b, m_c;

    cpu dut (
        .clk_cpu (clk),
        .reset   (reset),
        .inst    (inst),
        .pc      (pc)
    );

    initial clk = 1'b0;
    always #HCYCL clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: architectural effect of one instruction, plain integer arithmetic.
    task automatic model_step(input logic [7:0] i);
        int op, im, s, npc, nc;
        op  = int'(i[7:4]);
        im  = int'(i[3:0]);
        npc = (m_pc + 1) % 16;
        nc  = 0;
        case (op)
            0: begin s = m_a + im; m_a = s % 16; nc = (s > 15) ? 1 : 0; end
            5: begin s = m_b + im; m_b = s % 16; nc = (s > 15) ? 1 : 0; end
            3: m_a = im;
            7: m_b = im;
            1: m_a = m_b;
            4: m_b = m_a;
            2: m_a = 0;
            6: m_b = 0;
            15: npc = im;
            14: if (m_c == 0) npc = im;
            default: ;
        endcase
        m_c  = nc;
        m_pc = npc;
    endtask

    task automatic model_reset();
        m_pc = 0; m_a = 0; m_b = 0; m_c = 0;
    endtask

    // Called at a falling edge: drive inst for the next rising edge, queue the expectation.
    task automatic issue_model(input logic [7:0] i);
        exp_t e;
        inst = i;
        model_step(i);
        e.inst = i; e.pc = m_pc; e.a = m_a; e.b = m_b; e.c = m_c;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic issue_vec(input exp_t v);
        inst = v.inst;
        model_step(v.inst);
        exp_q.push_back(v);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " pc"}, int'(pc), 0);
        check({tag, " A"},  int'(dut.register_file_a.dat_out), 0);
        check({tag, " B"},  int'(dut.register_file_b.dat_out), 0);
        check({tag, " C"},  int'(dut.c_q), 0);
    endtask

    // Monitor: compare architectural state STROB after every edge that has an expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #STROB;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_step++;
            check($sformatf("step%0d inst=%02h pc", n_step, e.inst), int'(pc), e.pc);
            check($sformatf("step%0d inst=%02h A", n_step, e.inst),
                  int'(dut.register_file_a.dat_out), e.a);
            check($sformatf("step%0d inst=%02h B", n_step, e.inst),
                  int'(dut.register_file_b.dat_out), e.b);
            check($sformatf("step%0d inst=%02h C", n_step, e.inst), int'(dut.c_q), e.c);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_step  = 0;
        reset   = 1'b0;
        inst    = 8'h3f;
        model_reset();

        vecs = '{
            '{8'h33,  1, 3, 0, 0},
            '{8'h75,  2, 3, 5, 0},
            '{8'h10,  3, 5, 5, 0},
            '{8'h39,  4, 9, 5, 0},
            '{8'h40,  5, 9, 9, 0},
            '{8'h33,  6, 3, 9, 0},
            '{8'h0e,  7, 1, 9, 1},
            '{8'he8,  8, 1, 9, 0},
            '{8'he8,  8, 1, 9, 0},
            '{8'h75,  9, 1, 5, 0},
            '{8'h52, 10, 1, 7, 0},
            '{8'hff, 15, 1, 7, 0},
            '{8'h90,  0, 1, 7, 0},
            '{8'h36,  1, 6, 7, 0},
            '{8'h20,  2, 0, 7, 0},
            '{8'hb3,  3, 0, 7, 0}
        };

        // Reset held across 5 edges with a live instruction on the bus.
        repeat (5) @(negedge clk);
        check_zero("reset_hold");

        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            issue_vec(vecs[k]);
        end

        // Random programs, including carry chains feeding JNC.
        for (int k = 0; k < 300; k++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r[7:4] = 4'h0;
            issue_model(r);
        end

        // Mid-run asynchronous reset, away from any clock edge.
        issue_model(8'h3a);
        issue_model(8'h7c);
        issue_model(8'h0f);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        #STROB;
        check_zero("reset_low_edge");
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 100; k++) begin
            issue_model(8'($urandom));
        end

        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
